// File: rtl/stochastic_stream_decoder_if.sv
// rtl/stochastic_stream_decoder_if.sv - stream-in / result-out bundle for the stochastic decoder
interface stochastic_stream_decoder_if #(
   parameter int BIT_LENGTH = 128,
   parameter int CW         = $clog2(BIT_LENGTH + 1)
);
   logic                 start;
   logic                 bit_valid;
   logic                 bit_in;
   logic                 busy;
   logic                 done;
   logic [CW-1:0]        ones_count;
   logic signed [CW:0]   bipolar_value;

   modport master (
      output start, bit_valid, bit_in,
      input  busy, done, ones_count, bipolar_value
   );

   modport slave (
      input  start, bit_valid, bit_in,
      output busy, done, ones_count, bipolar_value
   );
endinterface

// File: rtl/stochastic_stream_decoder.sv
// rtl/stochastic_stream_decoder.sv - counts ones over a BIT_LENGTH-bit window and publishes unipolar/bipolar results
module stochastic_stream_decoder #(
   parameter int BIT_LENGTH = 128,
   parameter int CW         = $clog2(BIT_LENGTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   stochastic_stream_decoder_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

   localparam logic [CW-1:0] LAST   = CW'(BIT_LENGTH - 1);
   localparam logic [CW:0]   BL_EXT = (CW + 1)'(BIT_LENGTH);

   state_t             state_q, state_d;
   logic [CW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      ones_q;
   logic signed [CW:0] bip_q;
   logic               publish;
   logic [CW-1:0]      acc_inc;
   logic [CW:0]        two_acc;
   logic [CW:0]        bip_d;

   // The final bit must be included in the published count, so results are
   // taken from the incremented accumulator rather than the stored one.
   assign acc_inc = acc_q + CW'(bus.bit_in);
   assign two_acc = {acc_inc, 1'b0};
   assign bip_d   = two_acc - BL_EXT;

   assign bus.busy          = (state_q == ACCUM);
   assign bus.done          = (state_q == PUBLISH);
   assign bus.ones_count    = ones_q;
   assign bus.bipolar_value = bip_q;

   // Next-state and counter update; start always wins and clears the window.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      publish = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ACCUM;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         ACCUM: begin
            if (bus.start) begin
               idx_d = '0;
               acc_d = '0;
            end else if (bus.bit_valid) begin
               if (idx_q == LAST) begin
                  publish = 1'b1;
                  state_d = PUBLISH;
                  idx_d   = '0;
                  acc_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
                  acc_d = acc_inc;
               end
            end
         end
         PUBLISH: begin
            if (bus.start) begin
               state_d = ACCUM;
               idx_d   = '0;
               acc_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
         end
      endcase
   end

   // State, window counters and held results; results only change on publish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         ones_q  <= '0;
         bip_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         if (publish) begin
            ones_q <= acc_inc;
            bip_q  <= $signed(bip_d);
         end
      end
   end
endmodule

// File: tb/tb_stochastic_stream_decoder.sv
// tb/tb_stochastic_stream_decoder.sv - self-checking bench for stochastic_stream_decoder
module tb_stochastic_stream_decoder;
   localparam int BL = 128;
   localparam int CW = $clog2(BL + 1);

   typedef struct {
      int n_ones;
      bit alt;
      int gap_pct;
      int exp_ones;
      int exp_bip;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   cyc_no;

   // reference model: accepted bits of the open window and last published result
   bit   m_active;
   bit   m_pub;
   int   m_bits[$];
   int   m_ones;
   int   m_bip;

   vec_t tbl[6];

   stochastic_stream_decoder_if #(.BIT_LENGTH(BL), .CW(CW)) bus ();

   stochastic_stream_decoder #(.BIT_LENGTH(BL), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_pub    = 1'b0;
      m_bits.delete();
      m_ones   = 0;
      m_bip    = 0;
   endtask

   task automatic model_step(input logic s, input logic v, input logic b);
      int sum;
      m_pub = 1'b0;
      if (s) begin
         m_active = 1'b1;
         m_bits.delete();
      end else if (m_active && v) begin
         m_bits.push_back(b ? 1 : 0);
         if (m_bits.size() == BL) begin
            sum = 0;
            foreach (m_bits[k]) sum += m_bits[k];
            m_ones   = sum;
            m_bip    = 2 * sum - BL;
            m_pub    = 1'b1;
            m_active = 1'b0;
            m_bits.delete();
         end
      end
   endtask

   task automatic compare_all(input string name);
      logic [CW-1:0] e_o;
      logic [CW:0]   e_b;
      e_o = m_ones[CW-1:0];
      e_b = m_bip[CW:0];
      check(name, {bus.busy, bus.done, bus.ones_count, bus.bipolar_value},
            {m_active, m_pub, e_o, e_b});
   endtask

   // one clock: drive at posedge+1, advance, compare at posedge+1
   task automatic cyc(input logic s, input logic v, input logic b);
      bus.start     = s;
      bus.bit_valid = v;
      bus.bit_in    = b;
      model_step(s, v, b);
      @(posedge clk);
      #1;
      cyc_no++;
      compare_all($sformatf("cyc%0d", cyc_no));
   endtask

   // start (with a bit that must not count), then BL valid bits with random gaps
   task automatic run_window(input int n_ones, input bit alt, input int gap_pct);
      int bits[BL];
      int j, t;
      for (int i = 0; i < BL; i++) bits[i] = alt ? ((i % 2 == 0) ? 1 : 0) : ((i < n_ones) ? 1 : 0);
      if (!alt) begin
         for (int i = BL - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = bits[i]; bits[i] = bits[j]; bits[j] = t;
         end
      end
      cyc(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < BL; i++) begin
         while ($urandom_range(99, 0) < gap_pct) cyc(1'b0, 1'b0, 1'($urandom));
         cyc(1'b0, 1'b1, bits[i][0]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc_no   = 0;
      model_reset();
      tbl[0] = '{n_ones: 128, alt: 1'b0, gap_pct: 0,  exp_ones: 128, exp_bip: 128};
      tbl[1] = '{n_ones: 0,   alt: 1'b0, gap_pct: 0,  exp_ones: 0,   exp_bip: -128};
      tbl[2] = '{n_ones: 64,  alt: 1'b1, gap_pct: 0,  exp_ones: 64,  exp_bip: 0};
      tbl[3] = '{n_ones: 40,  alt: 1'b0, gap_pct: 30, exp_ones: 40,  exp_bip: -48};
      tbl[4] = '{n_ones: 96,  alt: 1'b0, gap_pct: 10, exp_ones: 96,  exp_bip: 64};
      tbl[5] = '{n_ones: 1,   alt: 1'b0, gap_pct: 50, exp_ones: 1,   exp_bip: -126};

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_ones", {24'd0, bus.ones_count}, 32'd0);
      check("rst_bip",  {23'd0, bus.bipolar_value}, 32'd0);
      rst_n = 1'b1;

      // IDLE ignores valid bits
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);

      // table-driven windows
      for (int k = 0; k < 6; k++) begin
         logic [CW:0] eb;
         run_window(tbl[k].n_ones, tbl[k].alt, tbl[k].gap_pct);
         eb = tbl[k].exp_bip[CW:0];
         check($sformatf("tbl%0d_done", k), {31'd0, bus.done}, 32'd1);
         check($sformatf("tbl%0d_ones", k), {24'd0, bus.ones_count}, tbl[k].exp_ones);
         check($sformatf("tbl%0d_bip", k),  {23'd0, bus.bipolar_value}, {23'd0, eb});
         cyc(1'b0, 1'b0, 1'b0);
         check($sformatf("tbl%0d_done_once", k), {31'd0, bus.done}, 32'd0);
         cyc(1'b0, 1'b0, 1'b0);
      end

      // restart: 50 ones are abandoned, then 96-of-128 window
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 1'b1);
      check("restart_hold_ones", {24'd0, bus.ones_count}, 32'd1);
      run_window(96, 1'b0, 5);
      check("restart_ones", {24'd0, bus.ones_count}, 32'd96);
      check("restart_bip",  {23'd0, bus.bipolar_value}, 32'd64);
      cyc(1'b0, 1'b0, 1'b0);

      // reset mid-window: outputs clear without waiting for an edge
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, 1'($urandom));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("amid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("amid_rst_done", {31'd0, bus.done}, 32'd0);
      check("amid_rst_ones", {24'd0, bus.ones_count}, 32'd0);
      check("amid_rst_bip",  {23'd0, bus.bipolar_value}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b1);
      run_window(32, 1'b0, 20);
      check("post_rst_ones", {24'd0, bus.ones_count}, 32'd32);
      check("post_rst_bip",  {23'd0, bus.bipolar_value}, 32'h1c0);

      // back-to-back: start in the PUBLISH cycle
      run_window(64, 1'b1, 0);
      check("b2b_first_done", {31'd0, bus.done}, 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      check("b2b_busy", {31'd0, bus.busy}, 32'd1);
      check("b2b_first_held", {24'd0, bus.ones_count}, 32'd64);
      for (int i = 0; i < BL; i++) cyc(1'b0, 1'b1, 1'b1);
      check("b2b_second_ones", {24'd0, bus.ones_count}, 32'd128);
      cyc(1'b0, 1'b0, 1'b0);

      // randomized traffic, including random aborts and gaps
      for (int i = 0; i < 3000; i++) begin
         logic s;
         s = m_active ? ($urandom_range(999, 0) < 2) : ($urandom_range(99, 0) < 10);
         cyc(s, ($urandom_range(99, 0) < 70), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
